// File: rtl/vga_sync_gen.sv
// vga_sync_gen: pixel-clock divider plus horizontal/vertical counters for the
// VGA pipeline. Produces registered HSync/VSync/video_on that line up with
// HCount/VCount in the same cycle, and a one-clock frame_start pulse when the
// counters roll over to (0,0).
module vga_sync_gen #(
  parameter int CLK_DIV   = 2,
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter bit SYNC_POL  = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  output logic [9:0] HCount,
  output logic [9:0] VCount,
  output logic       HSync,
  output logic       VSync,
  output logic       video_on,
  output logic       p_tick,
  output logic       frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  // A divider of 1 still needs a one-bit register so the decode stays uniform.
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  logic [DIV_W-1:0] div;
  logic             h_last;
  logic             v_last;
  logic [9:0]       h_next;
  logic [9:0]       v_next;
  logic             hs_active;
  logic             vs_active;
  logic             visible_next;

  // Pixel tick is decoded straight from the divider register.
  assign p_tick = (div == DIV_LAST);

  // Divider: count 0..CLK_DIV-1 and wrap on the tick.
  // NOTE: reset is sampled on the clock edge (synchronous), so it is simply the
  // highest-priority branch inside the clocked block, not in the sensitivity list.
  always_ff @(posedge clk) begin
    if (reset) begin
      div <= '0;
    end else if (p_tick) begin
      div <= '0;
    end else begin
      div <= div + DIV_W'(1);
    end
  end

  // Next-state counters; wrap is detected by equality so no overflow is relied on.
  always_comb begin
    h_last = (HCount == H_LAST);
    v_last = (VCount == V_LAST);
    h_next = HCount;
    v_next = VCount;
    if (p_tick) begin
      h_next = h_last ? 10'd0 : HCount + 10'd1;
      if (h_last) begin
        v_next = v_last ? 10'd0 : VCount + 10'd1;
      end
    end
  end

  // Sync and visibility windows evaluated on the next-state counts.
  always_comb begin
    hs_active    = (h_next >= HS_FIRST) && (h_next <= HS_LAST);
    vs_active    = (v_next >= VS_FIRST) && (v_next <= VS_LAST);
    visible_next = (h_next < H_VIS) && (v_next < V_VIS);
  end

  // Counters and timing outputs register together so they never skew.
  // NOTE: non-blocking assignments here so every register samples the
  // pre-edge values; blocking would let later lines see already-updated state.
  always_ff @(posedge clk) begin
    if (reset) begin
      HCount      <= '0;
      VCount      <= '0;
      HSync       <= ~SYNC_POL;
      VSync       <= ~SYNC_POL;
      video_on    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      HCount      <= h_next;
      VCount      <= v_next;
      frame_start <= p_tick && h_last && v_last;
      // Decoded outputs only move with the pixel tick, so they keep their
      // reset values until the first tick edge.
      if (p_tick) begin
        HSync    <= hs_active ? SYNC_POL : ~SYNC_POL;
        VSync    <= vs_active ? SYNC_POL : ~SYNC_POL;
        video_on <= visible_next;
      end
    end
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: directed bench for vga_sync_gen. One instance uses the
// default 640x480 timing (first line only), two use a reduced 16x10 geometry
// so whole frames fit in a short run: one with CLK_DIV=2 active-low sync,
// one with CLK_DIV=1 active-high sync.
module tb_vga_sync_gen;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // Default-parameter instance.
  logic [9:0] d_hc, d_vc;
  logic       d_hs, d_vs, d_von, d_tick, d_fs;
  // Reduced geometry: H 10+2+3+1=16, V 6+1+2+1=10, CLK_DIV=2, active-low.
  logic [9:0] s_hc, s_vc;
  logic       s_hs, s_vs, s_von, s_tick, s_fs;
  // Same geometry, CLK_DIV=1, active-high sync.
  logic [9:0] f_hc, f_vc;
  logic       f_hs, f_vs, f_von, f_tick, f_fs;

  vga_sync_gen dut_d (
    .clk(clk), .reset(reset), .HCount(d_hc), .VCount(d_vc), .HSync(d_hs),
    .VSync(d_vs), .video_on(d_von), .p_tick(d_tick), .frame_start(d_fs)
  );

  vga_sync_gen #(
    .CLK_DIV(2), .H_VISIBLE(10), .H_FRONT(2), .H_SYNC(3), .H_BACK(1),
    .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .SYNC_POL(1'b0)
  ) dut_s (
    .clk(clk), .reset(reset), .HCount(s_hc), .VCount(s_vc), .HSync(s_hs),
    .VSync(s_vs), .video_on(s_von), .p_tick(s_tick), .frame_start(s_fs)
  );

  vga_sync_gen #(
    .CLK_DIV(1), .H_VISIBLE(10), .H_FRONT(2), .H_SYNC(3), .H_BACK(1),
    .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .SYNC_POL(1'b1)
  ) dut_f (
    .clk(clk), .reset(reset), .HCount(f_hc), .VCount(f_vc), .HSync(f_hs),
    .VSync(f_vs), .video_on(f_von), .p_tick(f_tick), .frame_start(f_fs)
  );

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Statistics gathered while running.
  int dh_cnt = 0, dh_first = -1, dh_last = -1;
  int s_fs_cnt = 0, s_fs_first = -1, s_fs_second = -1, s_fs_wide = 0;
  int s_vis = 0, s_vs_cnt = 0, s_vs_first = -1, s_vs_last = -1;
  int f_fs_cnt = 0, f_fs_first = -1, f_fs_second = -1, f_fs_wide = 0;
  int f_vis = 0, f_vs_cnt = 0, f_hs_cnt = 0, f_hs_first = -1, f_hs_last = -1;
  int f_tick_lo = 0;
  logic s_fs_prev = 1'b0, f_fs_prev = 1'b0;
  logic found;

  initial begin
    // Five reset edges, then release on a falling edge (cycle 0 sample point).
    repeat (5) @(negedge clk);
    reset = 1'b0;

    check("d_rst_hc", d_hc, 0);
    check("d_rst_vc", d_vc, 0);
    check("d_rst_hs", d_hs, 1);
    check("d_rst_vs", d_vs, 1);
    check("d_rst_von", d_von, 0);
    check("d_rst_fs", d_fs, 0);
    check("d_rst_tick", d_tick, 0);
    check("f_rst_tick", f_tick, 1);
    check("f_rst_hs", f_hs, 0);
    check("f_rst_von", f_von, 0);

    for (int c = 0; c <= 1700; c++) begin
      if (c > 0) @(negedge clk);

      // Default instance: divider phase and first line.
      if (c == 1) begin
        check("d_tick_c1", d_tick, 1);
        check("d_hc_c1", d_hc, 0);
      end
      if (c == 2) begin
        check("d_hc_c2", d_hc, 1);
        check("d_vc_c2", d_vc, 0);
        check("d_tick_c2", d_tick, 0);
      end
      if (d_tick && d_vc == 10'd0 && c < 1600 && d_hs == 1'b0) begin
        dh_cnt++;
        if (dh_first < 0) dh_first = int'(d_hc);
        dh_last = int'(d_hc);
      end
      if (c == 1279) begin
        check("d_hc_639", d_hc, 639);
        check("d_von_639", d_von, 1);
      end
      if (c == 1281) begin
        check("d_hc_640", d_hc, 640);
        check("d_von_640", d_von, 0);
      end
      if (c == 1599) begin
        check("d_hc_799", d_hc, 799);
        check("d_vc_line0", d_vc, 0);
        check("d_tick_799", d_tick, 1);
      end
      if (c == 1600) begin
        check("d_hc_wrap", d_hc, 0);
        check("d_vc_wrap", d_vc, 1);
        check("d_fs_line", d_fs, 0);
      end

      // Reduced CLK_DIV=2 instance.
      if (s_fs) begin
        s_fs_cnt++;
        if (s_fs_first < 0) s_fs_first = c;
        else if (s_fs_second < 0) s_fs_second = c;
        if (s_fs_prev) s_fs_wide++;
      end
      s_fs_prev = s_fs;
      if (c >= 320 && c < 640 && s_tick) begin
        if (s_von) s_vis++;
        if (s_vs == 1'b0) begin
          s_vs_cnt++;
          if (s_vs_first < 0) s_vs_first = int'(s_vc);
          s_vs_last = int'(s_vc);
        end
      end
      if (c == 319) begin
        check("s_hc_last", s_hc, 15);
        check("s_vc_last", s_vc, 9);
      end
      if (c == 320) begin
        check("s_hc_00", s_hc, 0);
        check("s_vc_00", s_vc, 0);
      end
      if (c == 341) begin
        check("s_hc_10_0", s_hc, 10);
        check("s_von_10_0", s_von, 0);
      end
      if (c == 499) begin
        check("s_pos_9_5", {s_hc, s_vc}, {10'd9, 10'd5});
        check("s_von_9_5", s_von, 1);
      end
      if (c == 513) begin
        check("s_pos_0_6", {s_hc, s_vc}, {10'd0, 10'd6});
        check("s_von_0_6", s_von, 0);
      end

      // Reduced CLK_DIV=1 active-high instance.
      if (!f_tick) f_tick_lo++;
      if (f_fs) begin
        f_fs_cnt++;
        if (f_fs_first < 0) f_fs_first = c;
        else if (f_fs_second < 0) f_fs_second = c;
        if (f_fs_prev) f_fs_wide++;
      end
      f_fs_prev = f_fs;
      if (c >= 160 && c < 320) begin
        if (f_von) f_vis++;
        if (f_vs) f_vs_cnt++;
        if (f_hs && f_vc == 10'd0) begin
          f_hs_cnt++;
          if (f_hs_first < 0) f_hs_first = int'(f_hc);
          f_hs_last = int'(f_hc);
        end
      end
    end

    check("d_hsync_ticks", dh_cnt, 96);
    check("d_hsync_first", dh_first, 656);
    check("d_hsync_last", dh_last, 751);
    check("s_fs_first", s_fs_first, 320);
    check("s_fs_period", s_fs_second - s_fs_first, 320);
    check("s_fs_count", s_fs_cnt, 5);
    check("s_fs_wide", s_fs_wide, 0);
    check("s_visible", s_vis, 60);
    check("s_vsync_ticks", s_vs_cnt, 32);
    check("s_vsync_first", s_vs_first, 7);
    check("s_vsync_last", s_vs_last, 8);
    check("f_tick_low", f_tick_lo, 0);
    check("f_fs_first", f_fs_first, 160);
    check("f_fs_period", f_fs_second - f_fs_first, 160);
    check("f_fs_count", f_fs_cnt, 10);
    check("f_fs_wide", f_fs_wide, 0);
    check("f_visible", f_vis, 60);
    check("f_vsync_ticks", f_vs_cnt, 32);
    check("f_hsync_ticks", f_hs_cnt, 3);
    check("f_hsync_first", f_hs_first, 12);
    check("f_hsync_last", f_hs_last, 14);

    // Mid-frame reset inside both sync windows of the CLK_DIV=2 instance.
    found = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (s_tick && s_hc == 10'd13 && s_vc == 10'd7) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("s_reach_13_7", found, 1);
    check("s_hs_in_win", s_hs, 0);
    check("s_vs_in_win", s_vs, 0);
    reset = 1'b1;
    @(negedge clk);
    check("s_mid_hc", s_hc, 0);
    check("s_mid_vc", s_vc, 0);
    check("s_mid_hs", s_hs, 1);
    check("s_mid_vs", s_vs, 1);
    check("s_mid_von", s_von, 0);
    check("s_mid_fs", s_fs, 0);
    check("s_mid_tick", s_tick, 0);
    reset = 1'b0;
    @(negedge clk);
    check("s_post_tick", s_tick, 1);
    check("s_post_pos", {s_hc, s_vc}, 20'd0);
    check("s_post_von", s_von, 0);

    // Reset landing on the wrap tick of the CLK_DIV=1 instance: no pulse.
    repeat (158) @(negedge clk);
    check("f_pre_pos", {f_hc, f_vc}, {10'd15, 10'd9});
    reset = 1'b1;
    @(negedge clk);
    check("f_rst_fs", f_fs, 0);
    check("f_rst_pos", {f_hc, f_vc}, 20'd0);
    check("f_rst_hs2", f_hs, 0);
    check("f_rst_von2", f_von, 0);
    reset = 1'b0;
    @(negedge clk);
    check("f_rst_fs_after", f_fs, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
